// File: rtl/wb_sdram_arb.sv
// -----------------------------------------------------------------------------
// wb_sdram_arb
//
// Two-master Wishbone arbiter sitting in front of the SDRAM controller's single
// Wishbone slave port.
//
// Behaviour summary:
//   - No grant is issued until the SDRAM controller reports init complete.
//   - Masters are granted round-robin; the grant stays locked for the whole
//     bus cycle (while the granted master holds cyc), covering incrementing
//     bursts and strobe gaps.
//   - A watchdog counts strobe cycles without acknowledge; when it expires the
//     granted master receives a one-cycle error pulse and the arbiter parks in
//     ABORT until that master drops cyc.
//
// Parameters:
//   dw       Wishbone data width (sel width is dw/8)
//   TIMEOUT  strobe cycles without ack before abort, 1..255
//
// Ports:
//   sys_clk, RESETN         clock (rising edge) and asynchronous active-low reset
//   sdr_init_done           SDRAM initialization complete
//   m0_* / m1_*             Wishbone master ports (cyc/stb/we/addr/dat/sel/cti in,
//                           ack/err/dat out)
//   s_*                     Wishbone master port towards the SDRAM controller
// -----------------------------------------------------------------------------
module wb_sdram_arb #(
    parameter int dw      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              sys_clk,
    input  logic              RESETN,
    input  logic              sdr_init_done,

    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [25:0]       m0_addr_i,
    input  logic [dw-1:0]     m0_dat_i,
    input  logic [dw/8-1:0]   m0_sel_i,
    input  logic [2:0]        m0_cti_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic [dw-1:0]     m0_dat_o,

    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [25:0]       m1_addr_i,
    input  logic [dw-1:0]     m1_dat_i,
    input  logic [dw/8-1:0]   m1_sel_i,
    input  logic [2:0]        m1_cti_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [dw-1:0]     m1_dat_o,

    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [25:0]       s_addr_o,
    output logic [dw-1:0]     s_dat_o,
    output logic [dw/8-1:0]   s_sel_o,
    output logic [2:0]        s_cti_o,
    input  logic              s_ack_i,
    input  logic [dw-1:0]     s_dat_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        ABORT  = 2'd3
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_last;      // 1: m1 was granted most recently
    logic [7:0]  r_cnt;       // strobe-without-ack counter
    logic        r_abort_m;   // which master was aborted
    logic        r_err_pend;  // high during the first ABORT cycle only

    logic        w_req0;
    logic        w_req1;
    logic        w_granted;
    logic        w_stb;
    logic        w_timeout;
    logic        w_abort_cyc;

    assign w_req0    = m0_cyc_i & m0_stb_i;
    assign w_req1    = m1_cyc_i & m1_stb_i;
    assign w_granted = (r_state == GRANT0) || (r_state == GRANT1);

    // Strobe as seen by the slave; computed here so the watchdog does not
    // depend on the output process.
    assign w_stb = (r_state == GRANT0) ? m0_stb_i :
                   (r_state == GRANT1) ? m1_stb_i : 1'b0;

    // Expiry is detected one count early so the FSM lands in ABORT exactly
    // TIMEOUT cycles after the first unacknowledged strobe.
    assign w_timeout = w_stb & ~s_ack_i & (r_cnt == TO_LAST);

    assign w_abort_cyc = r_abort_m ? m1_cyc_i : m0_cyc_i;

    // State register
    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (sdr_init_done) begin
                    if (w_req0 && w_req1) begin
                        w_next = r_last ? GRANT0 : GRANT1;
                    end else if (w_req0) begin
                        w_next = GRANT0;
                    end else if (w_req1) begin
                        w_next = GRANT1;
                    end
                end
            end
            GRANT0: begin
                // A dropped cyc ends the cycle even if the watchdog fires
                // on the same edge.
                if (!m0_cyc_i) begin
                    w_next = IDLE;
                end else if (w_timeout) begin
                    w_next = ABORT;
                end
            end
            GRANT1: begin
                if (!m1_cyc_i) begin
                    w_next = IDLE;
                end else if (w_timeout) begin
                    w_next = ABORT;
                end
            end
            ABORT: begin
                if (!w_abort_cyc) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Round-robin history, watchdog counter and abort bookkeeping
    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            r_last     <= 1'b1;
            r_cnt      <= 8'd0;
            r_abort_m  <= 1'b0;
            r_err_pend <= 1'b0;
        end else begin
            if (r_state == IDLE && w_next == GRANT0) begin
                r_last <= 1'b0;
            end else if (r_state == IDLE && w_next == GRANT1) begin
                r_last <= 1'b1;
            end

            // Counter only runs while a strobe waits for ack; any ack, any
            // strobe gap and any non-granted state clear it.
            if (w_granted && w_stb && !s_ack_i) begin
                r_cnt <= r_cnt + 8'd1;
            end else begin
                r_cnt <= 8'd0;
            end

            if (r_state == GRANT0 && w_next == ABORT) begin
                r_abort_m <= 1'b0;
            end else if (r_state == GRANT1 && w_next == ABORT) begin
                r_abort_m <= 1'b1;
            end

            r_err_pend <= (w_next == ABORT) && (r_state != ABORT);
        end
    end

    // Output routing; everything defaults to zero so idle/abort states and
    // the non-granted master see a quiet bus.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_cti_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = '0;
        case (r_state)
            GRANT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = w_stb;
                s_we_o   = m0_we_i;
                s_addr_o = m0_addr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_cti_o  = m0_cti_i;
                m0_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
            end
            GRANT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = w_stb;
                s_we_o   = m1_we_i;
                s_addr_o = m1_addr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_cti_o  = m1_cti_i;
                m1_ack_o = s_ack_i;
                m1_dat_o = s_dat_i;
            end
            ABORT: begin
                m0_err_o = r_err_pend & ~r_abort_m;
                m1_err_o = r_err_pend &  r_abort_m;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_sdram_arb.sv
// -----------------------------------------------------------------------------
// tb_wb_sdram_arb
//
// Directed, self-checking bench for wb_sdram_arb (TIMEOUT = 16). The slave side
// is driven directly by the stimulus sequence. Outputs are sampled 1 time unit
// after the rising edge, or 1 unit after a mid-cycle input change for the
// combinational paths.
// -----------------------------------------------------------------------------
module tb_wb_sdram_arb;

    localparam int DW = 32;

    logic            sys_clk;
    logic            RESETN;
    logic            sdr_init_done;

    logic            m0_cyc_i, m0_stb_i, m0_we_i;
    logic [25:0]     m0_addr_i;
    logic [DW-1:0]   m0_dat_i;
    logic [DW/8-1:0] m0_sel_i;
    logic [2:0]      m0_cti_i;
    logic            m0_ack_o, m0_err_o;
    logic [DW-1:0]   m0_dat_o;

    logic            m1_cyc_i, m1_stb_i, m1_we_i;
    logic [25:0]     m1_addr_i;
    logic [DW-1:0]   m1_dat_i;
    logic [DW/8-1:0] m1_sel_i;
    logic [2:0]      m1_cti_i;
    logic            m1_ack_o, m1_err_o;
    logic [DW-1:0]   m1_dat_o;

    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [25:0]     s_addr_o;
    logic [DW-1:0]   s_dat_o;
    logic [DW/8-1:0] s_sel_o;
    logic [2:0]      s_cti_o;
    logic            s_ack_i;
    logic [DW-1:0]   s_dat_i;

    int n_checks;
    int n_pass;
    int n_fail;

    wb_sdram_arb #(.dw(DW), .TIMEOUT(16)) dut (
        .sys_clk       (sys_clk),
        .RESETN        (RESETN),
        .sdr_init_done (sdr_init_done),
        .m0_cyc_i      (m0_cyc_i),
        .m0_stb_i      (m0_stb_i),
        .m0_we_i       (m0_we_i),
        .m0_addr_i     (m0_addr_i),
        .m0_dat_i      (m0_dat_i),
        .m0_sel_i      (m0_sel_i),
        .m0_cti_i      (m0_cti_i),
        .m0_ack_o      (m0_ack_o),
        .m0_err_o      (m0_err_o),
        .m0_dat_o      (m0_dat_o),
        .m1_cyc_i      (m1_cyc_i),
        .m1_stb_i      (m1_stb_i),
        .m1_we_i       (m1_we_i),
        .m1_addr_i     (m1_addr_i),
        .m1_dat_i      (m1_dat_i),
        .m1_sel_i      (m1_sel_i),
        .m1_cti_i      (m1_cti_i),
        .m1_ack_o      (m1_ack_o),
        .m1_err_o      (m1_err_o),
        .m1_dat_o      (m1_dat_o),
        .s_cyc_o       (s_cyc_o),
        .s_stb_o       (s_stb_o),
        .s_we_o        (s_we_o),
        .s_addr_o      (s_addr_o),
        .s_dat_o       (s_dat_o),
        .s_sel_o       (s_sel_o),
        .s_cti_o       (s_cti_o),
        .s_ack_i       (s_ack_i),
        .s_dat_i       (s_dat_i)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "time limit reached");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;

        // ---------------- reset state with active-looking inputs ----------
        RESETN        = 1'b0;
        sdr_init_done = 1'b0;
        m0_cyc_i  = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1;
        m0_addr_i = 26'h0ABCDE; m0_dat_i = 32'h11112222;
        m0_sel_i  = 4'hF; m0_cti_i = 3'b000;
        m1_cyc_i  = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
        m1_addr_i = 26'h0000123; m1_dat_i = 32'h0;
        m1_sel_i  = 4'hF; m1_cti_i = 3'b000;
        s_ack_i   = 1'b1; s_dat_i = 32'hAAAA5555;
        #1;
        check("rst_s_cyc",  s_cyc_o,  0);
        check("rst_s_stb",  s_stb_o,  0);
        check("rst_s_addr", s_addr_o, 0);
        check("rst_s_dat",  s_dat_o,  0);
        check("rst_s_sel",  s_sel_o,  0);
        check("rst_m0_ack", m0_ack_o, 0);
        check("rst_m0_dat", m0_dat_o, 0);
        check("rst_m0_err", m0_err_o, 0);
        repeat (2) tick();
        RESETN  = 1'b1;
        s_ack_i = 1'b0;
        s_dat_i = 32'h0;

        // ---------------- init gating ----------------
        for (int i = 0; i < 20; i++) begin
            tick();
            check("init_gate_cyc", s_cyc_o, 0);
        end
        sdr_init_done = 1'b1;
        tick();
        check("init_grant_cyc",  s_cyc_o,  1);
        check("init_grant_stb",  s_stb_o,  1);
        check("init_grant_addr", s_addr_o, 26'h0ABCDE);
        check("init_grant_we",   s_we_o,   1);
        check("init_grant_dat",  s_dat_o,  32'h11112222);
        check("init_grant_sel",  s_sel_o,  4'hF);
        check("init_m0_noack",   m0_ack_o, 0);
        s_ack_i = 1'b1; s_dat_i = 32'h0BADF00D;
        #1;
        check("init_m0_ack",  m0_ack_o, 1);
        check("init_m0_dat",  m0_dat_o, 32'h0BADF00D);
        check("init_m1_ack",  m1_ack_o, 0);
        check("init_m1_dat",  m1_dat_o, 0);
        tick();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
        tick();
        check("idle_cyc", s_cyc_o, 0);
        s_ack_i = 1'b1;
        #1;
        check("idle_m0_ack", m0_ack_o, 0);
        check("idle_m0_dat", m0_dat_o, 0);
        s_ack_i = 1'b0;

        // ---------------- contention after a fresh reset ----------------
        RESETN = 1'b0;
        #1;
        RESETN = 1'b1;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 26'h0000040;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 26'h0000123;
        tick();
        check("cont_first_cyc",  s_cyc_o,  1);
        check("cont_first_addr", s_addr_o, 26'h0000040);
        s_ack_i = 1'b1; s_dat_i = 32'h12345678;
        #1;
        check("cont_m0_ack", m0_ack_o, 1);
        check("cont_m1_ack", m1_ack_o, 0);
        check("cont_m1_dat", m1_dat_o, 0);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
        tick();
        check("cont_gap_cyc", s_cyc_o, 0);
        tick();
        check("cont_m1_cyc",  s_cyc_o,  1);
        check("cont_m1_addr", s_addr_o, 26'h0000123);

        // ---------------- data routing to m1 ----------------
        s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF;
        #1;
        check("route_m1_dat", m1_dat_o, 32'hDEADBEEF);
        check("route_m1_ack", m1_ack_o, 1);
        check("route_m0_ack", m0_ack_o, 0);
        check("route_m0_dat", m0_dat_o, 0);
        check("route_s_we",   s_we_o,   0);

        // ---------------- re-request: m1 was last, so m0 wins ----------------
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        tick();
        check("rr_gap_cyc", s_cyc_o, 0);
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        check("rr_m0_addr", s_addr_o, 26'h0000040);

        // ---------------- burst lock ----------------
        s_ack_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m0_cti_i  = (i == 7) ? 3'b111 : 3'b010;
            m0_addr_i = 26'h0000100 + 26'(i);
            #1;
            check("burst_m0_ack", m0_ack_o, 1);
            check("burst_m1_ack", m1_ack_o, 0);
            check("burst_addr",   s_addr_o, 26'h0000100 + 26'(i));
            check("burst_cti",    s_cti_o,  (i == 7) ? 3'b111 : 3'b010);
            tick();
        end
        check("burst_hold_addr", s_addr_o, 26'h0000107);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_cti_i = 3'b000; s_ack_i = 1'b0;
        tick();
        check("burst_gap_cyc", s_cyc_o,  0);
        check("burst_gap_m1",  m1_ack_o, 0);
        tick();
        check("burst_m1_cyc",  s_cyc_o,  1);
        check("burst_m1_addr", s_addr_o, 26'h0000123);

        // ---------------- timeout ----------------
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_addr_i = 26'h0002000;
        tick();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        check("to_grant_addr", s_addr_o, 26'h0002000);
        for (int i = 1; i < 16; i++) begin
            tick();
            check("to_wait_err_cyc", {m0_err_o, s_cyc_o}, 2'b01);
        end
        tick();
        check("to_err",    m0_err_o, 1);
        check("to_m1_err", m1_err_o, 0);
        check("to_s_cyc",  s_cyc_o,  0);
        check("to_s_stb",  s_stb_o,  0);
        check("to_s_addr", s_addr_o, 0);
        check("to_m0_ack", m0_ack_o, 0);
        tick();
        check("to_err_pulse", m0_err_o, 0);
        check("to_abort_cyc", s_cyc_o,  0);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        check("to_idle_cyc", s_cyc_o, 0);
        tick();
        check("to_m1_cyc",  s_cyc_o,  1);
        check("to_m1_addr", s_addr_o, 26'h0000123);
        s_ack_i = 1'b1; s_dat_i = 32'hCAFEF00D;
        #1;
        check("to_m1_ack", m1_ack_o, 1);
        check("to_m1_dat", m1_dat_o, 32'hCAFEF00D);

        // ---------------- asynchronous reset mid-transfer ----------------
        #1;
        RESETN = 1'b0;
        #1;
        check("arst_s_cyc",  s_cyc_o,  0);
        check("arst_m1_ack", m1_ack_o, 0);
        check("arst_m1_dat", m1_dat_o, 0);
        repeat (2) tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        s_ack_i  = 1'b0;
        RESETN   = 1'b1;
        tick();
        check("arst_m0_cyc",  s_cyc_o,  1);
        check("arst_m0_addr", s_addr_o, 26'h0002000);

        // ---------------- init_done falling while granted ----------------
        sdr_init_done = 1'b0;
        tick();
        check("initdrop_hold_cyc", s_cyc_o, 1);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        tick();
        check("initdrop_no_grant1", s_cyc_o, 0);
        tick();
        check("initdrop_no_grant2", s_cyc_o, 0);
        sdr_init_done = 1'b1;
        tick();
        check("initdrop_regrant_addr", s_addr_o, 26'h0000123);
        check("initdrop_regrant_cyc",  s_cyc_o,  1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
